// File: rtl/tt_um_fsm.sv
// tt_um_fsm: overlapping serial 4-bit pattern detector with seven-segment match-depth display and detection counter
// Ports: clk, rst_n (async active-low), ena (enable),
//        ui_in {-, clear, valid, pattern[3:0], data}, uo_out {match, seg g..a},
//        uio_in (unused), uio_out (detection count), uio_oe (all driven)
module tt_um_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_hist, w_hist, w_pat;
  logic [2:0] r_rcv, w_rcv;
  logic [7:0] r_cnt;
  logic [6:0] r_seg;
  logic       r_flag;
  logic       w_unused;
  function automatic logic [6:0] seg7(input state_t s);
    return s == S0 ? 7'h3F : s == S1 ? 7'h06 : s == S2 ? 7'h5B : s == S3 ? 7'h4F : 7'h66;
  endfunction
  // Longest suffix of the updated history that is a prefix of the pattern,
  // limited by how many bits have actually been received.
  always_comb begin
    w_pat  = ui_in[4:1];
    w_hist = {r_hist[2:0], ui_in[0]};
    w_rcv  = r_rcv == 3'd4 ? 3'd4 : r_rcv + 3'd1;
    w_next = (w_rcv >= 3'd4 && w_hist == w_pat)            ? S4 :
             (w_rcv >= 3'd3 && w_hist[2:0] == w_pat[3:1])  ? S3 :
             (w_rcv >= 3'd2 && w_hist[1:0] == w_pat[3:2])  ? S2 :
             (w_hist[0] == w_pat[3])                       ? S1 : S0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S0;
      r_hist  <= '0;
      r_rcv   <= '0;
      r_cnt   <= '0;
      r_seg   <= 7'h3F;
      r_flag  <= 1'b0;
    end else if (ena && ui_in[6]) begin
      r_state <= S0;
      r_hist  <= '0;
      r_rcv   <= '0;
      r_cnt   <= '0;
      r_seg   <= 7'h3F;
      r_flag  <= 1'b0;
    end else if (ena && ui_in[5]) begin
      r_state <= w_next;
      r_hist  <= w_hist;
      r_rcv   <= w_rcv;
      r_cnt   <= r_cnt + {7'd0, w_next == S4};
      r_seg   <= seg7(w_next);
      r_flag  <= w_next == S4;
    end
  end
  assign uo_out   = {r_flag, r_seg};
  assign uio_out  = r_cnt;
  assign uio_oe   = 8'hFF;
  assign w_unused = &{1'b0, uio_in, ui_in[7], r_state};
endmodule

// File: tb/tb_tt_um_fsm.sv
// tb_tt_um_fsm: directed-vector self-checking bench for tt_um_fsm
module tb_tt_um_fsm;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       ena = 1;
  logic [7:0] ui_in = 0;
  logic [7:0] uio_in = 8'hA5;
  logic [7:0] uo_out, uio_out, uio_oe;
  int n_cmp = 0;
  int n_err = 0;
  tt_um_fsm dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask
  task automatic step(input logic b, input logic [3:0] p, input logic v, input logic c);
    ui_in = {1'b0, c, v, p, b};
    @(posedge clk);
    #1;
  endtask
  logic [7:0] exp_seq [0:8] = '{8'h06, 8'h5B, 8'h4F, 8'hE6, 8'h5B, 8'h4F, 8'hE6, 8'h5B, 8'h3F};
  logic [7:0] cnt_seq [0:8] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
  logic       bit_seq [0:8] = '{1, 0, 1, 1, 0, 1, 1, 0, 0};
  logic [7:0] ones_seq [0:5] = '{8'h06, 8'h5B, 8'h4F, 8'hE6, 8'hE6, 8'hE6};
  initial begin
    #12;
    check("rst_uo", uo_out, 8'h3F);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hFF);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) step(1, 4'b1011, 0, 0);
    check("idle_uo", uo_out, 8'h3F);
    check("idle_uio", uio_out, 8'h00);
    for (int i = 0; i < 9; i++) begin
      step(bit_seq[i], 4'b1011, 1, 0);
      check($sformatf("p1011_uo%0d", i), uo_out, exp_seq[i]);
      check($sformatf("p1011_cnt%0d", i), uio_out, cnt_seq[i]);
    end
    step(0, 4'b1111, 0, 1);
    check("clr_uo", uo_out, 8'h3F);
    check("clr_cnt", uio_out, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(1, 4'b1111, 1, 0);
      check($sformatf("p1111_uo%0d", i), uo_out, ones_seq[i]);
    end
    check("p1111_cnt", uio_out, 8'd3);
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 0, 0);
    check("hold_uo", uo_out, 8'hE6);
    check("hold_cnt", uio_out, 8'd3);
    step(1, 4'b1111, 1, 1);
    check("clrprio_uo", uo_out, 8'h3F);
    check("clrprio_cnt", uio_out, 8'h00);
    step(1, 4'b1111, 1, 0);
    step(1, 4'b1111, 1, 0);
    check("pre_ena_uo", uo_out, 8'h5B);
    ena = 0;
    for (int i = 0; i < 3; i++) step(1, 4'b1111, 1, 1);
    check("ena0_uo", uo_out, 8'h5B);
    ena = 1;
    step(1, 4'b1111, 1, 0);
    check("resume_uo", uo_out, 8'h4F);
    step(1, 4'b1111, 1, 0);
    check("resume_s4", uo_out, 8'hE6);
    check("resume_cnt", uio_out, 8'd1);
    #2;
    rst_n = 0;
    #1;
    check("arst_uo", uo_out, 8'h3F);
    check("arst_cnt", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1;
    step(0, 4'b0000, 1, 0);
    check("rcv_gate_uo", uo_out, 8'h06);
    for (int i = 1; i < 259; i++) begin
      step(0, 4'b0000, 1, 0);
      if (i == 3) check("wrap_first", uio_out, 8'd1);
      if (i == 257) check("wrap_255", uio_out, 8'd255);
    end
    check("wrap_cnt", uio_out, 8'h00);
    check("wrap_uo", uo_out, 8'hE6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
